// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared constants and state encoding for the cache line-fill
//               controller and its counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    // Line geometry: eight 16-bit words per 16-byte line
    localparam int LINE_WORDS = 8;
    localparam int WORD_OFF_W = 3;
    localparam int CNT_W      = 4;
    localparam int ADDR_W     = 16;

    // Slice of a byte address that identifies the line
    localparam int LINE_MSB   = 15;
    localparam int LINE_LSB   = 4;
    localparam int LINE_W     = LINE_MSB - LINE_LSB + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage : cache_pkg

`default_nettype wire

// File: rtl/fill_counter.sv
// ============================================================================
// Module      : fill_counter
// Description : Small up-counter with synchronous clear and enable that
//               saturates at MAX_COUNT instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fill_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] r_count;

    // Clear wins over enable; holding at the limit keeps a finished fill from re-issuing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count < C_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : fill_counter

`default_nettype wire

// File: rtl/cache_fill_fsm.sv
// ============================================================================
// Module      : cache_fill_fsm
// Description : Cache miss line-fill controller. Latches the missing line,
//               issues one read per word back-to-back, writes each returned
//               word into the data array and writes the tag with the last one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fill_fsm #(
    parameter int MEM_LAT    = 4,
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        fsm_busy,
    output logic        mem_req,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [2:0]  data_word_sel,
    output logic [15:0] data_out,
    output logic        write_tag_array,
    output logic [15:0] tag_address
);

    import cache_pkg::*;

    // The datapath is sized for an 8-word line; latency only shapes the bench's memory
    generate
        if ((LINE_WORDS != cache_pkg::LINE_WORDS) || (MEM_LAT < 1)) begin : g_bad_param
            $error("cache_fill_fsm: unsupported LINE_WORDS/MEM_LAT");
        end
    endgenerate

    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LINE_WORDS - 1);

    fill_state_t       r_state;
    logic [LINE_W-1:0] r_line;

    logic [CNT_W-1:0]  w_req_cnt;
    logic [CNT_W-1:0]  w_rcv_cnt;
    logic              w_in_fill;
    logic              w_start;
    logic              w_rcv_en;
    logic              w_last;
    logic              w_unused_offset;

    assign w_in_fill = (r_state == FILL);
    assign w_start   = (r_state == IDLE) && miss_detected;
    assign w_rcv_en  = w_in_fill && memory_data_valid;
    assign w_last    = w_rcv_en && (w_rcv_cnt == C_LAST);

    // Byte offset within the line plays no part in a whole-line fill
    assign w_unused_offset = ^miss_address[LINE_LSB-1:0];

    // Control state and latched line; the line is frozen for the whole fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_line  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (miss_detected) begin
                        r_line  <= miss_address[LINE_MSB:LINE_LSB];
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (w_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Requests issued so far; both counters restart on the miss that opens a fill
    fill_counter #(
        .WIDTH     (CNT_W),
        .MAX_COUNT (LINE_WORDS)
    ) u_req_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start),
        .en    (mem_req),
        .count (w_req_cnt)
    );

    // Words returned so far; advances independently of the request side
    fill_counter #(
        .WIDTH     (CNT_W),
        .MAX_COUNT (LINE_WORDS)
    ) u_rcv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start),
        .en    (w_rcv_en),
        .count (w_rcv_cnt)
    );

    assign fsm_busy         = w_in_fill;
    assign mem_req          = w_in_fill && (w_req_cnt < C_FULL);
    assign memory_address   = w_in_fill ? {r_line, w_req_cnt[WORD_OFF_W-1:0], 1'b0} : '0;
    assign write_data_array = w_rcv_en;
    assign data_word_sel    = w_rcv_cnt[WORD_OFF_W-1:0];
    assign data_out         = w_in_fill ? memory_data : '0;
    assign write_tag_array  = w_last;
    assign tag_address      = {r_line, {LINE_LSB{1'b0}}};

endmodule : cache_fill_fsm

`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
// ============================================================================
// Module      : tb_cache_fill_fsm
// Description : Self-checking bench for cache_fill_fsm with a fixed-latency
//               memory and a per-fill reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_fill_fsm;

    localparam int MEM_LAT    = 4;
    localparam int LINE_WORDS = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  data_word_sel;
    logic [15:0] data_out;
    logic        write_tag_array;
    logic [15:0] tag_address;

    always #5 clk = ~clk;

    cache_fill_fsm #(
        .MEM_LAT    (MEM_LAT),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_req           (mem_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .data_word_sel     (data_word_sel),
        .data_out          (data_out),
        .write_tag_array   (write_tag_array),
        .tag_address       (tag_address)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Outstanding memory reads: address and the cycle its word may return
    typedef struct {
        logic [15:0] addr;
        int          rdy;
    } mreq_t;
    mreq_t mq[$];

    // Reference model of one fill: line, cycle of first request, words received
    bit          m_busy;
    logic [15:0] m_line;
    int          m_start;
    int          m_rcv;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [31:0] p;
        p = {16'h0, a} * 32'h3A77;
        return p[15:0] ^ 16'hC35A;
    endfunction

    task automatic check_all_zero(input string tag);
        check_value({tag, "_busy"},  {31'b0, fsm_busy},         0);
        check_value({tag, "_req"},   {31'b0, mem_req},          0);
        check_value({tag, "_maddr"}, {16'b0, memory_address},   0);
        check_value({tag, "_wr"},    {31'b0, write_data_array}, 0);
        check_value({tag, "_sel"},   {29'b0, data_word_sel},    0);
        check_value({tag, "_dout"},  {16'b0, data_out},         0);
        check_value({tag, "_tagwr"}, {31'b0, write_tag_array},  0);
        check_value({tag, "_tag"},   {16'b0, tag_address},      0);
    endtask

    // One clock cycle: drive inputs, check outputs against the model mid-cycle, advance.
    // gap: 0 = memory answers as soon as ready, 1 = alternate cycles, 2 = random.
    task automatic run_cycle(input logic miss, input logic [15:0] addr, input int gap, input bit spurious);
        logic        v;
        logic [15:0] d;
        bit          go;
        int          k;
        bit          exp_req;
        bit          exp_wr;
        mreq_t       r;
        miss_detected = miss;
        miss_address  = addr;
        go = (gap == 0) || (gap == 1 && (cyc % 2) == 0) || (gap == 2 && $urandom_range(0, 1) == 1);
        v = 1'b0;
        d = 16'($urandom);
        if (mq.size() > 0 && mq[0].rdy <= cyc && go) begin
            v = 1'b1;
            d = mem_word(mq[0].addr);
            mq.delete(0);
        end else if (spurious && !m_busy && mq.size() == 0) begin
            v = 1'b1;
        end
        memory_data_valid = v;
        memory_data       = d;
        @(negedge clk);
        k       = cyc - m_start;
        exp_req = m_busy && (k < LINE_WORDS);
        exp_wr  = m_busy && v;
        check_value("busy",  {31'b0, fsm_busy}, {31'b0, m_busy});
        check_value("req",   {31'b0, mem_req},  {31'b0, exp_req});
        if (exp_req)
            check_value("maddr", {16'b0, memory_address}, {16'b0, m_line + 16'(2 * k)});
        else if (!m_busy)
            check_value("maddr_idle", {16'b0, memory_address}, 0);
        check_value("wr",    {31'b0, write_data_array}, {31'b0, exp_wr});
        check_value("tagwr", {31'b0, write_tag_array},  {31'b0, exp_wr && (m_rcv == LINE_WORDS - 1)});
        check_value("tag",   {16'b0, tag_address},      {16'b0, m_line});
        if (exp_wr) begin
            check_value("sel",  {29'b0, data_word_sel}, m_rcv);
            check_value("dout", {16'b0, data_out},      {16'b0, d});
        end
        if (mem_req) begin
            r.addr = memory_address;
            r.rdy  = cyc + MEM_LAT;
            mq.push_back(r);
        end
        if (!m_busy) begin
            if (miss) begin
                m_busy  = 1'b1;
                m_line  = addr & 16'hFFF0;
                m_start = cyc + 1;
                m_rcv   = 0;
            end
        end else if (v) begin
            m_rcv++;
            if (m_rcv == LINE_WORDS) m_busy = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Run until the model leaves the fill; noisy cycles toggle miss with random addresses
    task automatic wait_idle(input logic miss, input logic [15:0] addr, input int gap, input bit noise);
        int budget;
        budget = 0;
        while (m_busy && budget < 80) begin
            if (noise) run_cycle(1'($urandom_range(0, 1)), 16'($urandom), gap, 1'b0);
            else       run_cycle(miss, addr, gap, 1'b0);
            budget++;
        end
        check_value("fill_done", {31'b0, m_busy}, 0);
    endtask

    task automatic run_fill(input logic [15:0] addr, input int gap, input bit noise);
        run_cycle(1'b1, addr, gap, 1'b0);
        wait_idle(1'b0, 16'h0, gap, noise);
    endtask

    // Async reset pulse starting just after an edge; outputs must clear before the next edge
    task automatic reset_pulse();
        rst_n             = 1'b0;
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
        memory_data       = 16'hA5A5;
        #2;
        check_all_zero("async_rst");
        mq.delete();
        m_busy = 1'b0;
        m_line = 16'h0;
        m_rcv  = 0;
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic partial_fill_then_reset(input logic [15:0] addr, input int words, input int gap);
        int budget;
        run_cycle(1'b1, addr, gap, 1'b0);
        budget = 0;
        while (m_busy && m_rcv < words && budget < 60) begin
            run_cycle(1'b0, 16'h0, gap, 1'b0);
            budget++;
        end
        check_value("partial_rcv", m_rcv, words);
        reset_pulse();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        miss_detected     = 1'b0;
        miss_address      = 16'h0;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0;
        m_busy            = 1'b0;
        m_line            = 16'h0;
        m_start           = 0;
        m_rcv             = 0;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 1;

        // Spurious returns while idle must not write anything
        repeat (4) run_cycle(1'b0, 16'h0, 0, 1'b1);

        // Nominal fill of the line containing 0x1236
        run_fill(16'h1236, 0, 1'b0);
        repeat (2) run_cycle(1'b0, 16'h0, 0, 1'b0);

        // Memory answering on alternate cycles
        run_fill(16'hBEEF, 1, 1'b0);
        run_cycle(1'b0, 16'h0, 0, 1'b0);

        // Miss held high while the address moves; the new line starts right after
        run_cycle(1'b1, 16'h1236, 0, 1'b0);
        wait_idle(1'b1, 16'h4000, 0, 1'b0);
        run_cycle(1'b1, 16'h4000, 0, 1'b0);
        check_value("held_line", {16'b0, tag_address}, 32'h4000);
        wait_idle(1'b0, 16'h0, 0, 1'b0);

        // Reset after three words, then a clean fill
        partial_fill_then_reset(16'h2345, 3, 0);
        run_fill(16'h0080, 0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            int          idle_n;
            logic [15:0] a;
            int          g;
            idle_n = $urandom_range(0, 3);
            for (int j = 0; j < idle_n; j++)
                run_cycle(1'b0, 16'($urandom), 0, 1'($urandom_range(0, 1)));
            a = 16'($urandom);
            g = $urandom_range(0, 2);
            if ($urandom_range(0, 5) == 0)
                partial_fill_then_reset(a, $urandom_range(0, 7), g);
            else
                run_fill(a, g, 1'b1);
        end
        repeat (3) run_cycle(1'b0, 16'h0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cache_fill_fsm

`default_nettype wire

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter: MEM_LAT, default 4, cycles from memory request to its memory_data_valid response (informational; FSM counts responses, not cycles).
REQ-002 Parameter: LINE_WORDS, default 8, 16-bit words per cache line (block = 16 bytes).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 miss_detected  in  1  cache lookup missed this cycle; sampled only in IDLE.
REQ-006 miss_address  in  16  byte address of missing access.
REQ-007 memory_data_valid  in  1  memory returns one word this cycle.
REQ-008 memory_data  in  16  returned word.
REQ-009 fsm_busy  out  1  fill in progress; pipeline stalls while high.
REQ-010 mem_req  out  1  memory read request this cycle.
REQ-011 memory_address  out  16  address of current request.
REQ-012 write_data_array  out  1  write data_out into data array this cycle.
REQ-013 data_word_sel  out  3  word offset within line for the data write.
REQ-014 data_out  out  16  word to write (memory_data passed through).
REQ-015 write_tag_array  out  1  write tag/valid for latched line address this cycle.
REQ-016 tag_address  out  16  latched line base address {miss_address[15:4], 4'h0}.

Function
REQ-017 States SHALL be IDLE and FILL only.
REQ-018 IDLE: miss_detected=1 at edge N latches miss_address[15:4], clears req_cnt and rcv_cnt, enters FILL at N+1.
REQ-019 FILL: fsm_busy=1; mem_req=1 while req_cnt<8; memory_address={line[15:4], req_cnt, 1'b0}; req_cnt increments each cycle mem_req=1.
REQ-020 Requests issue back-to-back: cycles N+1..N+8 carry word offsets 0..7, ascending.
REQ-021 FILL: write_data_array=memory_data_valid (combinational); data_word_sel=rcv_cnt; data_out=memory_data; rcv_cnt increments on each valid.
REQ-022 write_tag_array=1 in exactly the cycle of the 8th valid (rcv_cnt=7 and valid), coincident with last data write.
REQ-023 After 8th valid, state returns to IDLE next edge; fsm_busy low from that cycle. Nominal fill: busy for 8+MEM_LAT cycles, N+1..N+8+MEM_LAT.
REQ-024 miss_detected in FILL SHALL be ignored; miss_address changes in FILL SHALL not affect latched line.
REQ-025 memory_data_valid in IDLE SHALL be ignored: no array writes.
REQ-026 Valid arriving while requests still issuing (MEM_LAT<8) SHALL be counted normally; both counters advance independently in same cycle.
REQ-027 Counters are 4-bit (0..8); req_cnt saturates at 8, never wraps to reissue.
REQ-028 Miss asserted in the cycle FSM returns to IDLE SHALL start a new fill next edge (no dead cycle beyond IDLE).
REQ-029 In IDLE: mem_req, write_data_array, write_tag_array = 0; memory_address = 0.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, counters=0, latched line=0, all outputs 0, independent of clk.
REQ-031 Reset mid-fill SHALL abandon the fill; no tag write issued; partial data writes are left to tag-valid to mask.

Structure
REQ-032 Shared package cache_pkg: LINE_WORDS, WORD_OFF_W=3, state encoding IDLE/FILL, line-address slice constants.
REQ-033 One sub-module fill_counter (4-bit, async reset, enable, clear, saturate at 8), instantiated twice (req, rcv).

Verification
REQ-034 Miss at 0x1236, MEM_LAT=4 -> mem_req addresses 0x1230..0x123E cycles N+1..N+8; 8 data writes sel 0..7 cycles N+5..N+12; tag write at N+12 with tag_address 0x1230; busy low N+13.
REQ-035 Memory with gaps (valid on alternate cycles) -> 8 writes, sel strictly 0..7, tag write only with 8th valid.
REQ-036 miss_detected held high, address changed to 0x4000 during fill -> no effect; new fill of 0x4000 starts next edge after return to IDLE.
REQ-037 rst_n pulsed low after 3 returned words -> outputs 0 asynchronously, no tag write; next miss to 0x0080 performs full clean fill.
REQ-038 Spurious memory_data_valid in IDLE -> write_data_array and write_tag_array stay 0.
